// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module : instr_fetch_unit_pkg
// Brief  : Shared default widths and depth for the instruction prefetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;
    localparam int unsigned c_instr_width  = 16;
    localparam int unsigned c_i_addr_width = 10;
    localparam int unsigned c_fetch_depth  = 4;
endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Brief  : Generic synchronous FIFO with push/pop/flush, count and registered head.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = c_instr_width + c_i_addr_width,
    parameter int unsigned DEPTH = c_fetch_depth,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             w_pop;
    logic [CNT_W-1:0] w_remain;

    assign w_pop    = pop_i && (count_q != '0);
    assign w_remain = count_q - CNT_W'(w_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            head_d   = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
            count_d  = w_remain + CNT_W'(push_i);
            // The head register looks ahead: a word pushed into an otherwise
            // empty queue bypasses storage and becomes the head directly.
            if (count_d == '0) begin
                head_d = '0;
            end else if (w_remain == '0) begin
                head_d = push_data_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_data_o  = head_q;
    assign count_o      = count_q;
endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : ROM prefetch stage feeding PC-tagged instruction words to the control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = c_instr_width,
    parameter int unsigned I_ADDR_WIDTH = c_i_addr_width,
    parameter int unsigned DEPTH        = c_fetch_depth,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    rom_req_o,
    output logic [I_ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [INSTR_WIDTH-1:0]  rom_data_i,
    input  logic                    pc_load_i,
    input  logic [I_ADDR_WIDTH-1:0] pc_target_i,
    output logic                    instr_valid_o,
    output logic [INSTR_WIDTH-1:0]  instr_o,
    output logic [I_ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                    instr_ready_i,
    output logic [CNT_W-1:0]        fifo_count_o
);
    localparam int unsigned ENTRY_W = I_ADDR_WIDTH + INSTR_WIDTH;
    localparam int unsigned OCC_W   = CNT_W + 1;
    localparam logic [OCC_W-1:0] c_depth = OCC_W'(DEPTH);

    logic [I_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [I_ADDR_WIDTH-1:0] issue_pc_q, issue_pc_d;
    logic                    inflight_q, inflight_d;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_issue;
    logic [OCC_W-1:0]        w_occupancy;
    logic [ENTRY_W-1:0]      w_head;

    // A redirect overrides any pop and drops the response still in flight.
    assign w_pop  = instr_valid_o && instr_ready_i && !pc_load_i;
    assign w_push = inflight_q && !pc_load_i;

    // Slots are reserved at issue time so the capture never meets a full queue.
    assign w_occupancy = OCC_W'(fifo_count_o) + OCC_W'(inflight_q) - OCC_W'(w_pop);
    assign w_issue     = !reset && !pc_load_i && (w_occupancy < c_depth);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        inflight_d = w_issue;
        if (pc_load_i) begin
            fetch_pc_d = pc_target_i;
        end else if (w_issue) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
            issue_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= '0;
            issue_pc_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (w_push),
        .push_data_i  ({issue_pc_q, rom_data_i}),
        .pop_i        (w_pop),
        .flush_i      (pc_load_i),
        .head_valid_o (instr_valid_o),
        .head_data_o  (w_head),
        .count_o      (fifo_count_o)
    );

    assign rom_req_o  = w_issue;
    assign rom_addr_o = fetch_pc_q;
    assign instr_pc_o = w_head[ENTRY_W-1:INSTR_WIDTH];
    assign instr_o    = w_head[INSTR_WIDTH-1:0];
endmodule

`default_nettype wire
